boolean_sweep_ctrl: RTL and testbench
=====================================

// Module: boolean_sweep_ctrl
// PURPOSE
//  Sequencer for the 3-input Boolean combinational block (inputs A,B,C, output F).
//  - On start, drives every input vector 0..2^N_IN-1 onto the block in turn.
//  - Samples F after a settle delay and builds the captured truth table.
//  - Compares the table against a golden table latched at start; reports pass/fail,
//    mismatch count and first failing vector.
//  - Sits between the Boolean datapath and a host or self-test wrapper.
// PARAMETERS
//  N_IN    3  number of Boolean inputs; vector bit N_IN-1 = A (MSB), bit 0 = C
//  SETTLE  1  cycles each vector is held before F is sampled; legal range >= 1
// PORTS
//  clk        in   1          rising-edge clock
//  reset      in   1          asynchronous, active-high reset
//  start      in   1          begin sweep; honoured only in IDLE
//  abort      in   1          cancel sweep; honoured in IDLE and APPLY
//  expected   in   2**N_IN    golden truth table; bit i = F for vector i; latched on start
//  f_in       in   1          F output of the Boolean block
//  abc        out  N_IN       vector driven to the Boolean block (registered)
//  busy       out  1          high while in APPLY
//  done       out  1          one-cycle pulse when a sweep completes
//  pass       out  1          1 = captured table == expected; valid from done, held until next start
//  table_out  out  2**N_IN    captured truth table; bit i = sampled F for vector i
//  fail_cnt   out  N_IN+1     number of mismatching vectors
//  fail_idx   out  N_IN       index of first mismatch; 0 when fail_cnt==0
// BEHAVIOUR
//  - Reset (async, any state): state=IDLE; abc, busy, done, pass, table_out, fail_cnt,
//    fail_idx, internal idx/settle counter/golden reg all 0. Takes effect without a clock edge.
//  - All outputs are registered. States: IDLE, APPLY, DONE.
//  - IDLE:
//    - start & !abort: latch expected; idx=0; abc=0; cnt=0; clear table_out, fail_cnt,
//      fail_idx and pass; busy=1; go to APPLY.
//    - start & abort in the same cycle: abort wins; stay in IDLE, nothing changes.
//  - APPLY: abc=idx is held stable; cnt increments each cycle.
//    - On the edge where cnt==SETTLE-1: table_out[idx]<=f_in and cnt<=0.
//    - If f_in != golden[idx]: fail_cnt++; if this is the first mismatch, fail_idx<=idx.
//    - idx < 2^N_IN-1: idx++ and abc<=idx+1.
//    - idx == 2^N_IN-1: go to DONE; busy=0; done=1.
//      pass<=(final fail_cnt==0), including any mismatch on this last sample.
//  - APPLY abort:
//    - abort=1 on any APPLY edge: go to IDLE; busy=0; abc=0; pass=0; done not pulsed.
//    - Partial table_out and fail_cnt are held.
//    - abort wins over a sample on the same edge; that sample is discarded.
//  - DONE: lasts exactly 1 cycle, then IDLE with done=0.
//    - start is ignored in DONE; it is accepted on the next IDLE cycle.
//  - Latency: start edge -> done high = 2^N_IN*SETTLE + 1 cycles (8*SETTLE+1 at defaults).
//  - Boundaries:
//    - start while busy is ignored.
//    - Changes on expected after start are ignored.
//    - idx never wraps; the sweep ends at 2^N_IN-1.
//    - fail_cnt saturates naturally at 2^N_IN (width N_IN+1).
// TESTING  (Boolean model F = ~(A&B) | C -> table 8'hBF; F=0 only at A=1,B=1,C=0)
//  1. reset=1, no clock -> all outputs 0 immediately; release; idle 3 cycles -> abc=0, busy=0.
//  2. expected=8'hBF, start 1 cycle, SETTLE=1 -> busy 8 cycles, abc steps 0..7,
//     done 1 cycle at +9, pass=1, table_out=8'hBF, fail_cnt=0.
//  3. expected=8'hFF, start -> done, pass=0, table_out=8'hBF, fail_cnt=1, fail_idx=6.
//  4. start, abort on 3rd APPLY cycle -> IDLE next edge, busy=0, abc=0, done never pulses,
//     pass=0, table_out[1:0] captured.
//  5. start pulsed mid-sweep and in DONE -> ignored (abc sequence unbroken);
//     start&abort together in IDLE -> stays IDLE.
//  6. Async reset asserted mid-sweep (abc=4) -> outputs 0 without a clock edge;
//     after release, a new start runs a full clean sweep: pass=1 with expected=8'hBF.

Source files
------------

// File: rtl/boolean_sweep_ctrl.sv
// Truth-table sweep sequencer for an N_IN-input Boolean block: drives every input
// vector, samples F after SETTLE cycles, and compares against a golden table latched at start.
module boolean_sweep_ctrl #(
  parameter int N_IN   = 3,
  parameter int SETTLE = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 abort,
  input  logic [2**N_IN-1:0]   expected,
  input  logic                 f_in,
  output logic [N_IN-1:0]      abc,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [2**N_IN-1:0]   table_out,
  output logic [N_IN:0]        fail_cnt,
  output logic [N_IN-1:0]      fail_idx
);

  localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CW-1:0]   SETTLE_LAST = CW'(SETTLE - 1);
  localparam logic [N_IN-1:0] IDX_LAST    = '1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_APPLY = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  logic [1:0]           state;
  logic [N_IN-1:0]      idx;
  logic [CW-1:0]        cnt;
  logic [2**N_IN-1:0]   golden;
  logic                 mismatch;

  assign mismatch = f_in ^ golden[idx];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      idx       <= '0;
      cnt       <= '0;
      golden    <= '0;
      abc       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      table_out <= '0;
      fail_cnt  <= '0;
      fail_idx  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          done <= 1'b0;
          if (start && !abort) begin
            golden    <= expected;
            idx       <= '0;
            abc       <= '0;
            cnt       <= '0;
            table_out <= '0;
            fail_cnt  <= '0;
            fail_idx  <= '0;
            pass      <= 1'b0;
            busy      <= 1'b1;
            state     <= S_APPLY;
          end
        end
        S_APPLY: begin
          // Abort takes priority over the sample that would land on this edge.
          if (abort) begin
            busy  <= 1'b0;
            abc   <= '0;
            pass  <= 1'b0;
            cnt   <= '0;
            state <= S_IDLE;
          end else if (cnt == SETTLE_LAST) begin
            cnt            <= '0;
            table_out[idx] <= f_in;
            if (mismatch) begin
              fail_cnt <= fail_cnt + (N_IN+1)'(1);
              if (fail_cnt == '0)
                fail_idx <= idx;
            end
            if (idx == IDX_LAST) begin
              busy  <= 1'b0;
              done  <= 1'b1;
              pass  <= (fail_cnt == '0) && !mismatch;
              state <= S_DONE;
            end else begin
              idx <= idx + 1'b1;
              abc <= idx + 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_DONE: begin
          done  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_boolean_sweep_ctrl.sv
// Directed bench for boolean_sweep_ctrl using the model F = ~(A&B) | C (table 8'hBF).
module tb_boolean_sweep_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [7:0] expected = '0;
  logic       f_in;
  logic [2:0] abc;
  logic       busy, done, pass;
  logic [7:0] table_out;
  logic [3:0] fail_cnt;
  logic [2:0] fail_idx;

  int tests = 0;
  int failed = 0;

  always #5 clk = ~clk;

  assign f_in = ~(abc[2] & abc[1]) | abc[0];

  boolean_sweep_ctrl #(.N_IN(3), .SETTLE(1)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .expected(expected), .f_in(f_in), .abc(abc), .busy(busy),
    .done(done), .pass(pass), .table_out(table_out),
    .fail_cnt(fail_cnt), .fail_idx(fail_idx)
  );

  typedef struct packed {
    logic [7:0] gold;
    logic       exp_pass;
    logic [7:0] exp_table;
    logic [3:0] exp_cnt;
    logic [2:0] exp_idx;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Starts a sweep and follows it until done; golden input is scrambled after start.
  task automatic run_sweep(input logic [7:0] gold, input bit mid_start);
    int cyc;
    int busy_cycles;
    bit abc_ok;
    expected = gold;
    start = 1'b1;
    tick();
    start = 1'b0;
    expected = ~gold;
    cyc = 1;
    busy_cycles = 0;
    abc_ok = 1'b1;
    while (!done && cyc < 40) begin
      if (busy) begin
        if (abc !== 3'(busy_cycles)) abc_ok = 1'b0;
        busy_cycles++;
      end
      start = mid_start && (busy_cycles == 4);
      tick();
      cyc++;
    end
    start = 1'b0;
    check("done_latency", cyc, 9);
    check("busy_cycles", busy_cycles, 8);
    check("abc_sequence", abc_ok, 1);
  endtask

  initial begin
    vecs[0] = '{8'hBF, 1'b1, 8'hBF, 4'd0, 3'd0};
    vecs[1] = '{8'hFF, 1'b0, 8'hBF, 4'd1, 3'd6};
    vecs[2] = '{8'h3F, 1'b0, 8'hBF, 4'd1, 3'd7};
    vecs[3] = '{8'hBE, 1'b0, 8'hBF, 4'd1, 3'd0};
    vecs[4] = '{8'h00, 1'b0, 8'hBF, 4'd7, 3'd0};
    vecs[5] = '{8'h40, 1'b0, 8'hBF, 4'd8, 3'd0};

    // Test 1: async reset with no clock edge
    #1 reset = 1'b1;
    #1;
    check("reset_outputs", {abc, busy, done, pass, table_out, fail_cnt, fail_idx}, 0);
    #1 reset = 1'b0;
    repeat (3) tick();
    check("idle_abc", abc, 0);
    check("idle_busy", busy, 0);

    // Tests 2/3 and variants: table-driven full sweeps
    for (int i = 0; i < 6; i++) begin
      run_sweep(vecs[i].gold, 1'b0);
      check("pass", pass, vecs[i].exp_pass);
      check("table_out", table_out, vecs[i].exp_table);
      check("fail_cnt", fail_cnt, vecs[i].exp_cnt);
      check("fail_idx", fail_idx, vecs[i].exp_idx);
      tick();
      check("done_pulse_width", done, 0);
      tick();
    end

    // Test 4: abort on the third APPLY cycle
    begin
      bit done_seen;
      done_seen = 1'b0;
      run_sweep(8'hBF, 1'b0);
      tick();
      tick();
      expected = 8'hFE;
      start = 1'b1;
      tick();
      start = 1'b0;
      check("abort_apply1_abc", abc, 0);
      tick();
      tick();
      check("abort_apply3_abc", abc, 2);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      check("abort_busy", busy, 0);
      check("abort_abc", abc, 0);
      check("abort_pass", pass, 0);
      check("abort_table", table_out, 8'h03);
      check("abort_fail_cnt", fail_cnt, 1);
      check("abort_fail_idx", fail_idx, 0);
      for (int k = 0; k < 4; k++) begin
        if (done) done_seen = 1'b1;
        tick();
      end
      check("abort_no_done", done_seen, 0);
      check("abort_stays_idle", busy, 0);
    end

    // Test 5: start mid-sweep and in DONE is ignored; start&abort in IDLE stays idle
    run_sweep(8'hBF, 1'b1);
    check("midstart_pass", pass, 1);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("done_start_done_low", done, 0);
    check("done_start_ignored", busy, 0);
    tick();
    check("done_start_still_idle", busy, 0);
    expected = 8'h00;
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    check("start_abort_busy", busy, 0);
    check("start_abort_table_kept", table_out, 8'hBF);
    check("start_abort_pass_kept", pass, 1);

    // Test 6: async reset mid-sweep, then a clean sweep
    begin
      int guard;
      expected = 8'hBF;
      start = 1'b1;
      tick();
      start = 1'b0;
      guard = 0;
      while (abc != 3'd4 && guard < 20) begin
        tick();
        guard++;
      end
      check("reach_abc4", abc, 4);
      #2 reset = 1'b1;
      #1;
      check("midsweep_reset", {abc, busy, done, pass, table_out, fail_cnt, fail_idx}, 0);
      reset = 1'b0;
      tick();
      check("post_reset_idle", busy, 0);
      run_sweep(8'hBF, 1'b0);
      check("post_reset_pass", pass, 1);
      check("post_reset_table", table_out, 8'hBF);
      check("post_reset_fail_cnt", fail_cnt, 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
